// File: rtl/datapath_gen.sv
// Microcoded datapath: register file, X/Y/Z/PSW/IR latches, address mux and a single-outstanding memory bus FSM.
// Optional bus watchdog enabled by defining DATAPATH_BUS_TIMEOUT_EN.
module datapath_gen #(
    parameter int WIDTH   = 16,
    parameter int NREG    = 8,
    parameter int CW      = 3,
    parameter int TIMEOUT = 16,
    localparam int RW     = $clog2(NREG)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [RW-1:0]    ctl_reg_src,
    input  logic [RW-1:0]    ctl_reg_dst,
    input  logic             ctl_reg_we,
    input  logic             ctl_reg_input,
    input  logic [1:0]       ctl_alu_input,
    input  logic [2:0]       ctl_mem_addr,
    input  logic             ctl_mem_rd,
    input  logic             ctl_mem_we,
    input  logic             ctl_mem_byte,
    input  logic             ctl_x_we,
    input  logic             ctl_y_we,
    input  logic             ctl_z_we,
    input  logic             ctl_psw_we,
    input  logic             ctl_ir_we,
    input  logic [CW-1:0]    cycle_next,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_d,
    input  logic [7:0]       alu_ps,
    output logic [7:0]       psw,
    output logic [WIDTH-1:0] ir,
    output logic [CW-1:0]    cycle,
    output logic             step,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    output logic             mem_req,
    output logic             mem_wr,
    output logic             mem_byte,
    input  logic [WIDTH-1:0] mem_rdata,
    input  logic             mem_ack,
    output logic             bus_err
);

    if (NREG < 2 || (NREG & (NREG - 1)) != 0) begin : g_bad_nreg
        $error("NREG must be a power of two");
    end
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("TIMEOUT must be at least 1");
    end

`ifdef DATAPATH_BUS_TIMEOUT_EN
    typedef enum logic [1:0] {S_IDLE, S_BUS, S_DONE, S_ERR} state_t;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    logic [TW-1:0] tcnt;
`else
    typedef enum logic [1:0] {S_IDLE, S_BUS, S_DONE} state_t;
`endif

    state_t           state;
    logic [WIDTH-1:0] regs [NREG];
    logic [WIDTH-1:0] x_q, y_q, z_q, rbuf;
    logic [WIDTH-1:0] src_val, dst_val, sel_addr, reg_wdata;
    logic             access;

    assign src_val   = regs[ctl_reg_src];
    assign dst_val   = regs[ctl_reg_dst];
    assign alu_a     = ctl_alu_input[0] ? x_q : src_val;
    assign alu_b     = ctl_alu_input[1] ? y_q : dst_val;
    assign access    = ctl_mem_rd | ctl_mem_we;
    assign reg_wdata = ctl_reg_input ? rbuf : alu_d;
    // step is combinational so a register-only microcycle commits in the same clock it is presented
    assign step      = (state == S_DONE) || (state == S_IDLE && !access);

    always_comb begin
        sel_addr = z_q;
        case (ctl_mem_addr)
            3'd0: sel_addr = src_val;
            3'd1: sel_addr = src_val + x_q;
            3'd2: sel_addr = dst_val;
            3'd3: sel_addr = dst_val + y_q;
            3'd4: sel_addr = x_q;
            3'd5: sel_addr = y_q;
            default: sel_addr = z_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int unsigned i = 0; i < NREG; i++) regs[i] <= '0;
            x_q       <= '0;
            y_q       <= '0;
            z_q       <= '0;
            rbuf      <= '0;
            psw       <= '0;
            ir        <= '0;
            cycle     <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_req   <= 1'b0;
            mem_wr    <= 1'b0;
            mem_byte  <= 1'b0;
            state     <= S_IDLE;
`ifdef DATAPATH_BUS_TIMEOUT_EN
            tcnt      <= '0;
            bus_err   <= 1'b0;
`endif
        end else begin
            if (step) begin
                if (ctl_reg_we) regs[ctl_reg_dst] <= reg_wdata;
                if (ctl_x_we)   x_q <= rbuf;
                if (ctl_y_we)   y_q <= rbuf;
                if (ctl_z_we)   z_q <= sel_addr;
                if (ctl_psw_we) psw <= alu_ps;
                if (ctl_ir_we)  ir  <= rbuf;
                cycle <= cycle_next;
            end
            case (state)
                S_IDLE: if (access) begin
                    mem_addr  <= sel_addr;
                    mem_wdata <= alu_d;
                    mem_wr    <= ctl_mem_we;
                    mem_byte  <= ctl_mem_byte;
                    mem_req   <= 1'b1;
                    state     <= S_BUS;
`ifdef DATAPATH_BUS_TIMEOUT_EN
                    tcnt      <= '0;
`endif
                end
                S_BUS: if (mem_ack) begin
                    rbuf    <= mem_rdata;
                    mem_req <= 1'b0;
                    mem_wr  <= 1'b0;
                    state   <= S_DONE;
`ifdef DATAPATH_BUS_TIMEOUT_EN
                end else if (tcnt == TW'(TIMEOUT - 1)) begin
                    mem_req <= 1'b0;
                    mem_wr  <= 1'b0;
                    bus_err <= 1'b1;
                    state   <= S_ERR;
                end else begin
                    tcnt <= tcnt + 1'b1;
`endif
                end
                S_DONE: state <= S_IDLE;
                default: state <= state;
            endcase
        end
    end

`ifndef DATAPATH_BUS_TIMEOUT_EN
    assign bus_err = 1'b0;
`endif

endmodule

// File: tb/tb_datapath_gen.sv
// Self-checking bench for datapath_gen: directed microcycles plus randomized traffic against a microcycle-level model.
// Covers the DATAPATH_BUS_TIMEOUT_EN watchdog when that macro is defined.
module tb_datapath_gen;

    localparam int WIDTH = 16;
    localparam int NREG = 8;
    localparam int CW = 3;
    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [2:0]  ctl_reg_src, ctl_reg_dst, ctl_mem_addr;
    logic        ctl_reg_we, ctl_reg_input, ctl_mem_rd, ctl_mem_we, ctl_mem_byte;
    logic        ctl_x_we, ctl_y_we, ctl_z_we, ctl_psw_we, ctl_ir_we;
    logic [1:0]  ctl_alu_input;
    logic [2:0]  cycle_next, cycle;
    logic [15:0] alu_a, alu_b, alu_d, ir, mem_addr, mem_wdata, mem_rdata;
    logic [7:0]  alu_ps, psw;
    logic        step, mem_req, mem_wr, mem_byte, mem_ack, bus_err;

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0] m_reg [NREG];
    logic [15:0] m_x, m_y, m_z, m_rbuf, m_ir;
    logic [7:0]  m_psw;
    logic [2:0]  m_cyc;

    datapath_gen #(.WIDTH(WIDTH), .NREG(NREG), .CW(CW), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .ctl_reg_src(ctl_reg_src), .ctl_reg_dst(ctl_reg_dst), .ctl_reg_we(ctl_reg_we),
        .ctl_reg_input(ctl_reg_input), .ctl_alu_input(ctl_alu_input), .ctl_mem_addr(ctl_mem_addr),
        .ctl_mem_rd(ctl_mem_rd), .ctl_mem_we(ctl_mem_we), .ctl_mem_byte(ctl_mem_byte),
        .ctl_x_we(ctl_x_we), .ctl_y_we(ctl_y_we), .ctl_z_we(ctl_z_we),
        .ctl_psw_we(ctl_psw_we), .ctl_ir_we(ctl_ir_we), .cycle_next(cycle_next),
        .alu_a(alu_a), .alu_b(alu_b), .alu_d(alu_d), .alu_ps(alu_ps),
        .psw(psw), .ir(ir), .cycle(cycle), .step(step),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_req(mem_req), .mem_wr(mem_wr),
        .mem_byte(mem_byte), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic clear_ctl();
        ctl_reg_src = '0; ctl_reg_dst = '0; ctl_mem_addr = '0; ctl_alu_input = '0;
        ctl_reg_we = 0; ctl_reg_input = 0; ctl_mem_rd = 0; ctl_mem_we = 0; ctl_mem_byte = 0;
        ctl_x_we = 0; ctl_y_we = 0; ctl_z_we = 0; ctl_psw_we = 0; ctl_ir_we = 0;
        cycle_next = '0; alu_d = '0; alu_ps = '0; mem_ack = 0; mem_rdata = '0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < NREG; i++) m_reg[i] = '0;
        m_x = '0; m_y = '0; m_z = '0; m_rbuf = '0; m_ir = '0; m_psw = '0; m_cyc = '0;
    endtask

    // Called just after a negedge with controls applied; returns just after the negedge following commit.
    task automatic run_micro(input int ack_delay, input logic [15:0] rd_val, output logic [15:0] used_addr);
        logic [15:0] s, d, a, md;
        logic        acc;
        int          n;
        #1;
        s = m_reg[ctl_reg_src];
        d = m_reg[ctl_reg_dst];
        case (ctl_mem_addr)
            3'd0: a = s;
            3'd1: a = s + m_x;
            3'd2: a = d;
            3'd3: a = d + m_y;
            3'd4: a = m_x;
            3'd5: a = m_y;
            default: a = m_z;
        endcase
        used_addr = a;
        md = m_rbuf;
        acc = ctl_mem_rd | ctl_mem_we;
        check("alu_a", alu_a, ctl_alu_input[0] ? m_x : s);
        check("alu_b", alu_b, ctl_alu_input[1] ? m_y : d);
        check("step_issue", step, !acc);
        if (acc) begin
            @(posedge clk);
            n = 0;
            while (n < ack_delay) begin
                @(negedge clk);
                n++;
                check("bus_req", mem_req, 1);
                check("bus_addr", mem_addr, a);
                check("bus_wdata", mem_wdata, alu_d);
                check("bus_wr", mem_wr, ctl_mem_we);
                check("bus_byte", mem_byte, ctl_mem_byte);
                check("bus_step", step, 0);
                check("bus_cycle", cycle, m_cyc);
                if (n == ack_delay) begin
                    mem_ack = 1;
                    mem_rdata = rd_val;
                    md = rd_val;
                end
                @(posedge clk);
            end
            @(negedge clk);
            mem_ack = 0;
            mem_rdata = 16'($urandom);
            check("done_req", mem_req, 0);
            check("done_step", step, 1);
            m_rbuf = md;
        end
        @(posedge clk);
        if (ctl_reg_we) m_reg[ctl_reg_dst] = ctl_reg_input ? md : alu_d;
        if (ctl_x_we) m_x = md;
        if (ctl_y_we) m_y = md;
        if (ctl_z_we) m_z = a;
        if (ctl_psw_we) m_psw = alu_ps;
        if (ctl_ir_we) m_ir = md;
        m_cyc = cycle_next;
        @(negedge clk);
        mem_ack = 0;
        check("psw", psw, m_psw);
        check("ir", ir, m_ir);
        check("cycle", cycle, m_cyc);
    endtask

    task automatic do_reset();
        clear_ctl();
        reset = 0;
        @(posedge clk);
        @(negedge clk);
        reset = 1;
        model_reset();
    endtask

    logic [15:0] addr;
    int          sel;

    initial begin
        clear_ctl();
        do_reset();
        #1;
        check("rst_psw", psw, 0);
        check("rst_ir", ir, 0);
        check("rst_cycle", cycle, 0);
        check("rst_req", mem_req, 0);
        check("rst_wr", mem_wr, 0);
        check("rst_err", bus_err, 0);
        check("rst_step", step, 1);

        // Instruction fetch from PC = 0, ack on first bus clock
        clear_ctl();
        ctl_reg_src = 3'd7; ctl_mem_addr = 3'd0; ctl_mem_rd = 1; ctl_ir_we = 1; cycle_next = 3'd5;
        run_micro(1, 16'o012700, addr);
        check("fetch_addr", addr, 16'o000000);
        check("fetch_ir", ir, 16'o012700);
        check("fetch_cycle", cycle, 3'd5);

        // Register write from alu_d; src on the same register must show the old value
        clear_ctl();
        ctl_reg_src = 3'd2; ctl_reg_dst = 3'd2; ctl_reg_we = 1; alu_d = 16'o177776; cycle_next = 3'd1;
        run_micro(1, '0, addr);
        ctl_reg_we = 0;
        #1 check("r2_new", alu_a, 16'o177776);

        // X = 4 via a read delayed 5 clocks
        clear_ctl();
        ctl_mem_rd = 1; ctl_x_we = 1; ctl_mem_addr = 3'd2; cycle_next = 3'd3;
        run_micro(5, 16'd4, addr);

        // R2 + X wraps around
        clear_ctl();
        ctl_reg_src = 3'd2; ctl_mem_addr = 3'd1; ctl_mem_rd = 1; ctl_z_we = 1;
        run_micro(2, 16'h1234, addr);
        check("wrap_addr", mem_addr, 16'o000002);

        // Randomized microcycles
        for (int it = 0; it < 200; it++) begin
            clear_ctl();
            ctl_reg_src = 3'($urandom); ctl_reg_dst = 3'($urandom);
            ctl_mem_addr = 3'($urandom); ctl_alu_input = 2'($urandom);
            ctl_reg_we = 1'($urandom); ctl_reg_input = 1'($urandom);
            ctl_x_we = 1'($urandom); ctl_y_we = 1'($urandom); ctl_z_we = 1'($urandom);
            ctl_psw_we = 1'($urandom); ctl_ir_we = 1'($urandom); ctl_mem_byte = 1'($urandom);
            cycle_next = 3'($urandom); alu_d = 16'($urandom); alu_ps = 8'($urandom);
            sel = int'($urandom_range(0, 2));
            ctl_mem_rd = (sel == 1);
            ctl_mem_we = (sel == 2);
            if (sel == 0) begin
                mem_ack = 1'($urandom);
                mem_rdata = 16'($urandom);
            end
            run_micro(int'($urandom_range(1, 6)), 16'($urandom), addr);
        end

        // Reset asserted in the middle of a bus access
        clear_ctl();
        ctl_mem_rd = 1; ctl_reg_we = 1; ctl_reg_input = 1; ctl_reg_dst = 3'd3; ctl_psw_we = 1; alu_ps = 8'hA5;
        @(posedge clk);
        @(negedge clk);
        check("abort_req_before", mem_req, 1);
        reset = 0;
        @(posedge clk);
        @(negedge clk);
        check("abort_req", mem_req, 0);
        check("abort_wr", mem_wr, 0);
        reset = 1;
        clear_ctl();
        model_reset();
        #1;
        check("abort_step", step, 1);
        check("abort_psw", psw, m_psw);
        check("abort_ir", ir, m_ir);
        check("abort_cycle", cycle, m_cyc);
        for (int r = 0; r < NREG; r++) begin
            ctl_reg_src = 3'(r);
            #1 check("abort_reg", alu_a, m_reg[r]);
        end
        ctl_reg_src = '0;
        ctl_alu_input = 2'b11;
        #1;
        check("abort_x", alu_a, m_x);
        check("abort_y", alu_b, m_y);
        ctl_alu_input = 2'b00;
        @(negedge clk);

`ifdef DATAPATH_BUS_TIMEOUT_EN
        clear_ctl();
        ctl_mem_rd = 1; ctl_reg_we = 1;
        #1 check("to_issue_step", step, 0);
        @(posedge clk);
        for (int k = 1; k <= TIMEOUT; k++) begin
            @(negedge clk);
            check("to_req", mem_req, 1);
            check("to_err_early", bus_err, 0);
            check("to_step", step, 0);
        end
        @(negedge clk);
        check("to_req_drop", mem_req, 0);
        check("to_err", bus_err, 1);
        check("to_step_err", step, 0);
        mem_ack = 1;
        repeat (3) @(negedge clk);
        check("to_err_sticky", bus_err, 1);
        check("to_step_sticky", step, 0);
        check("to_req_sticky", mem_req, 0);
        do_reset();
        #1 check("to_err_cleared", bus_err, 0);
        @(negedge clk);
        clear_ctl();
        ctl_mem_rd = 1; ctl_x_we = 1; cycle_next = 3'd6;
        run_micro(TIMEOUT, 16'h5A5A, addr);
        check("to_last_ack_err", bus_err, 0);
`endif
        check("final_err", bus_err, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
